// File: rtl/serial_logic16.sv
// serial_logic16: bit-serial AND/OR/NOT/XOR over a WIDTH-bit word, LSB first, with valid/ready on both sides.
module serial_logic16 #(
  parameter int WIDTH = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out,
  output logic             busy
);
  localparam int CW = $clog2(WIDTH);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state, state_nx;
  logic [WIDTH-1:0] a_sh, b_sh, res_sh;
  logic [1:0] op_q;
  logic [CW-1:0] cnt;
  logic r, last, accept;
  assign last = cnt == CW'(WIDTH - 1);
  assign accept = in_valid && in_ready;
  always_comb r = op_q == 2'b00 ? a_sh[0] & b_sh[0] :
                  op_q == 2'b01 ? a_sh[0] | b_sh[0] :
                  op_q == 2'b10 ? ~a_sh[0] : a_sh[0] ^ b_sh[0];
  always_comb begin
    in_ready  = state == IDLE;
    out_valid = state == DONE;
    busy      = state != IDLE;
    state_nx  = (state == IDLE && in_valid) ? RUN :
                (state == RUN && last) ? DONE :
                (state == DONE && out_ready) ? IDLE : state;
  end
  always_ff @(posedge clock)
    if (reset) state <= IDLE;
    else state <= state_nx;
  always_ff @(posedge clock) begin
    if (reset) begin
      a_sh   <= '0;
      b_sh   <= '0;
      res_sh <= '0;
      op_q   <= '0;
      cnt    <= '0;
      out    <= '0;
    end else if (accept) begin
      a_sh <= a;
      b_sh <= b;
      op_q <= op;
      cnt  <= '0;
    end else if (state == RUN) begin
      a_sh   <= a_sh >> 1;
      b_sh   <= b_sh >> 1;
      res_sh <= {r, res_sh[WIDTH-1:1]};
      cnt    <= cnt + 1'b1;
      // out only changes here so consumers never observe a partial word
      if (last) out <= {r, res_sh[WIDTH-1:1]};
    end
  end
endmodule

// File: tb/tb_serial_logic16.sv
// tb_serial_logic16: directed vectors with hand-computed results for serial_logic16.
module tb_serial_logic16;
  logic clock = 0, reset = 1, in_valid = 0, out_ready = 0;
  logic [1:0] op = 0;
  logic [15:0] a = 0, b = 0;
  logic in_ready, out_valid, busy;
  logic [15:0] out;
  int checks = 0, failures = 0;
  serial_logic16 dut (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
    .out(out), .busy(busy)
  );
  always #5 clock = ~clock;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  task automatic step;
    @(posedge clock);
    #1;
  endtask
  task automatic accept(input logic [1:0] o, input logic [15:0] x, input logic [15:0] y);
    op = o; a = x; b = y; in_valid = 1;
    step;
    in_valid = 0;
  endtask
  task automatic wait_done(input string tag, input int exp_lat);
    int n = 0;
    while (!out_valid && n < 40) begin
      chk({tag, "_busy_run"}, busy, 1);
      step;
      n++;
    end
    chk({tag, "_latency"}, n, exp_lat);
  endtask
  task automatic consume(input string tag);
    out_ready = 1;
    step;
    out_ready = 0;
    chk({tag, "_idle_ready"}, in_ready, 1);
    chk({tag, "_idle_valid"}, out_valid, 0);
    chk({tag, "_idle_busy"}, busy, 0);
  endtask
  task automatic run_op(input string tag, input logic [1:0] o, input logic [15:0] x,
                        input logic [15:0] y, input logic [15:0] exp);
    accept(o, x, y);
    wait_done(tag, 16);
    chk({tag, "_out"}, out, exp);
    consume(tag);
    chk({tag, "_out_held"}, out, exp);
  endtask
  initial begin
    step;
    step;
    reset = 0;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out", out, 16'h0000);
    chk("rst_busy", busy, 0);
    step;
    chk("idle_stays", busy, 0);
    // accept in cycle k; now in k+1, result first valid in k+17
    run_op("and", 2'b00, 16'hF0F0, 16'hFF00, 16'hF000);
    run_op("or", 2'b01, 16'h1234, 16'h8001, 16'h9235);
    run_op("not", 2'b10, 16'h00FF, 16'hFFFF, 16'hFF00);
    run_op("xor", 2'b11, 16'hAAAA, 16'hFFFF, 16'h5555);
    accept(2'b11, 16'h1111, 16'h2222);
    wait_done("bp", 16);
    for (int i = 0; i < 10; i++) begin
      in_valid = i[0];
      a = 16'hDEAD; b = 16'hBEEF; op = 2'b01;
      step;
      chk("bp_valid", out_valid, 1);
      chk("bp_out", out, 16'h3333);
      chk("bp_in_ready", in_ready, 0);
    end
    in_valid = 0;
    consume("bp");
    step;
    chk("bp_no_accept", busy, 0);
    chk("bp_out_after", out, 16'h3333);
    accept(2'b00, 16'hFFFF, 16'hFFFF);
    a = 0; b = 0; op = 2'b01; in_valid = 1;
    for (int i = 0; i < 5; i++) step;
    in_valid = 0;
    wait_done("chg", 11);
    chk("chg_out", out, 16'hFFFF);
    consume("chg");
    accept(2'b01, 16'h1234, 16'h4321);
    for (int i = 0; i < 7; i++) step;
    reset = 1;
    step;
    reset = 0;
    chk("mid_rst_ready", in_ready, 1);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_out", out, 16'h0000);
    begin
      int seen = 0;
      for (int i = 0; i < 20; i++) begin
        if (out_valid) seen++;
        step;
      end
      chk("mid_rst_no_valid", seen, 0);
    end
    run_op("post_rst", 2'b00, 16'h0F0F, 16'h0F0F, 16'h0F0F);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
